muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide instructions, in the execution stage beside the single-cycle ALU. It accepts an M-extension operation with its two operands and runs a 32-iteration shift-add multiply or restoring divide. While it works, it asserts a stall that holds IF/ID/EX. It pulses a one-cycle done strobe with the 32-bit result, which the EX stage muxes onto its ALU output for the EX/MEM register.

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32-cycle shift-add multiply and restoring divide,
// with a combinational pipeline stall and a one-cycle done strobe carrying the result.
module muldiv_sequencer (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Start,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Source1,
    input  logic [31:0] i_Source2,
    input  logic        i_Flush,
    output logic        o_Stall,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [31:0] o_Result,
    output logic [1:0]  o_State
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Handshake: an op is taken in IDLE when i_Start=1 and i_Flush=0; EX must hold
    // i_Start/operands while o_Stall=1 and sees the result in the cycle o_Done=1.
    logic        accept, is_div, s1_signed, s2_signed, neg1, neg2;
    logic        div_zero, div_ovf, fast;
    logic [31:0] mag1, mag2, fast_result;

    logic [2:0]  op_funct3;
    logic        op_neg1, op_neg2;
    logic [63:0] mcand, acc;
    logic [31:0] quo, opb;
    logic [4:0]  count;

    logic [63:0] mul_acc_nxt, prod_s;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_rem_nxt, div_quo_nxt, quo_s, rem_s, run_result;

    always_comb begin
        is_div    = i_Funct3[2];
        s1_signed = (i_Funct3 == 3'b001) | (i_Funct3 == 3'b010) |
                    (i_Funct3 == 3'b100) | (i_Funct3 == 3'b110);
        s2_signed = (i_Funct3 == 3'b001) | (i_Funct3 == 3'b100) | (i_Funct3 == 3'b110);
        neg1      = s1_signed & i_Source1[31];
        neg2      = s2_signed & i_Source2[31];
        mag1      = neg1 ? (~i_Source1 + 32'd1) : i_Source1;
        mag2      = neg2 ? (~i_Source2 + 32'd1) : i_Source2;
        div_zero  = is_div & (i_Source2 == 32'd0);
        div_ovf   = is_div & ~i_Funct3[0] & (i_Source1 == 32'h8000_0000) &
                    (i_Source2 == 32'hFFFF_FFFF);
        fast      = div_zero | div_ovf;
        accept    = (state == IDLE) & i_Start & ~i_Flush;
        if (div_zero) fast_result = i_Funct3[1] ? i_Source1 : 32'hFFFF_FFFF;
        else          fast_result = i_Funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end

    // One iteration of each algorithm; the last iteration's values feed the result directly.
    always_comb begin
        mul_acc_nxt = quo[0] ? (acc + mcand) : acc;
        div_shift   = {acc[31:0], quo[31]};
        div_fits    = (div_shift >= {1'b0, opb});
        div_rem_nxt = div_fits ? (div_shift[31:0] - opb) : div_shift[31:0];
        div_quo_nxt = {quo[30:0], div_fits};
        prod_s      = (op_neg1 ^ op_neg2) ? (~mul_acc_nxt + 64'd1) : mul_acc_nxt;
        quo_s       = (op_neg1 ^ op_neg2) ? (~div_quo_nxt + 32'd1) : div_quo_nxt;
        rem_s       = op_neg1 ? (~div_rem_nxt + 32'd1) : div_rem_nxt;
        if (op_funct3[2]) run_result = op_funct3[1] ? rem_s : quo_s;
        else              run_result = (op_funct3[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : RUN;
            RUN:     if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_Flush) state_next = IDLE;
    end

    always_comb begin
        o_Stall = i_Reset_n & (accept | ((state == RUN) & ~i_Flush));
        o_State = state;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            op_funct3 <= 3'd0;
            op_neg1   <= 1'b0;
            op_neg2   <= 1'b0;
            mcand     <= 64'd0;
            acc       <= 64'd0;
            quo       <= 32'd0;
            opb       <= 32'd0;
            count     <= 5'd0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Result  <= 32'd0;
        end else begin
            if (accept) begin
                op_funct3 <= i_Funct3;
                op_neg1   <= neg1;
                op_neg2   <= neg2;
                count     <= 5'd0;
                acc       <= 64'd0;
                if (is_div) begin
                    quo   <= mag1;
                    opb   <= mag2;
                    mcand <= 64'd0;
                end else begin
                    mcand <= {32'd0, mag1};
                    quo   <= mag2;
                    opb   <= 32'd0;
                end
            end else if (state == RUN) begin
                count <= count + 5'd1;
                if (op_funct3[2]) begin
                    acc <= {32'd0, div_rem_nxt};
                    quo <= div_quo_nxt;
                end else begin
                    acc   <= mul_acc_nxt;
                    mcand <= {mcand[62:0], 1'b0};
                    quo   <= {1'b0, quo[31:1]};
                end
            end
            o_Busy <= (state_next != IDLE);
            o_Done <= (state_next == DONE);
            if (state_next == DONE) o_Result <= (state == IDLE) ? fast_result : run_result;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, fast paths, flush and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        i_Reset_n, i_Start, i_Flush;
    logic [2:0]  i_Funct3;
    logic [31:0] i_Source1, i_Source2;
    logic        o_Stall, o_Busy, o_Done;
    logic [31:0] o_Result;
    logic [1:0]  o_State;

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .i_Clock   (clk),
        .i_Reset_n (i_Reset_n),
        .i_Start   (i_Start),
        .i_Funct3  (i_Funct3),
        .i_Source1 (i_Source1),
        .i_Source2 (i_Source2),
        .i_Flush   (i_Flush),
        .o_Stall   (o_Stall),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done),
        .o_Result  (o_Result),
        .o_State   (o_State)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one op in the current cycle (T) and follow it to DONE and back to idle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit fast, input string tag);
        int stall_n;
        int early_done;
        stall_n    = 0;
        early_done = 0;
        i_Start    = 1'b1;
        i_Funct3   = f;
        i_Source1  = a;
        i_Source2  = b;
        exp_q.push_back(exp);
        #1;
        check_eq({tag, "_stall_T"}, {31'd0, o_Stall}, 32'd1);
        tick;
        i_Start   = 1'b0;
        i_Source1 = $urandom;
        i_Source2 = $urandom;
        if (!fast) begin
            for (int k = 0; k < 32; k++) begin
                if (o_Stall) stall_n++;
                if (o_Done) early_done++;
                tick;
                i_Source1 = $urandom;
                i_Source2 = $urandom;
            end
            check_eq({tag, "_stall_run"}, stall_n, 32'd32);
            check_eq({tag, "_early_done"}, early_done, 32'd0);
        end
        check_eq({tag, "_done"}, {31'd0, o_Done}, 32'd1);
        check_eq({tag, "_busy_done"}, {31'd0, o_Busy}, 32'd1);
        check_eq({tag, "_stall_done"}, {31'd0, o_Stall}, 32'd0);
        check_eq({tag, "_result"}, o_Result, exp_q.pop_front());
        last_result = exp;
        tick;
        check_eq({tag, "_done_after"}, {31'd0, o_Done}, 32'd0);
        check_eq({tag, "_busy_after"}, {31'd0, o_Busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_n;
        i_Reset_n = 1'b0;
        i_Start   = 1'b0;
        i_Flush   = 1'b0;
        i_Funct3  = 3'd0;
        i_Source1 = 32'd0;
        i_Source2 = 32'd0;
        repeat (3) tick;
        i_Start = 1'b1;
        #1;
        check_eq("rst_stall", {31'd0, o_Stall}, 32'd0);
        check_eq("rst_busy", {31'd0, o_Busy}, 32'd0);
        check_eq("rst_done", {31'd0, o_Done}, 32'd0);
        check_eq("rst_result", o_Result, 32'd0);
        check_eq("rst_state", {30'd0, o_State}, 32'd0);
        i_Start   = 1'b0;
        i_Reset_n = 1'b1;
        tick;

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, "div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, "rem");
        run_op(3'b101, 32'd100,        32'd7,          32'h0000_000E, 1'b0, "divu");
        run_op(3'b111, 32'd100,        32'd7,          32'h0000_0002, 1'b0, "remu");
        run_op(3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, "divu_z");
        run_op(3'b110, 32'd5,          32'd0,          32'd5,         1'b1, "rem_z");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ovf");

        // Flush a DIVU at T+10, then accept a MUL at T+11.
        i_Start   = 1'b1;
        i_Funct3  = 3'b101;
        i_Source1 = 32'd1000;
        i_Source2 = 32'd3;
        tick;
        i_Start = 1'b0;
        repeat (9) tick;
        i_Flush = 1'b1;
        tick;
        i_Flush = 1'b0;
        check_eq("flush_busy", {31'd0, o_Busy}, 32'd0);
        check_eq("flush_done", {31'd0, o_Done}, 32'd0);
        check_eq("flush_result_held", o_Result, last_result);
        run_op(3'b000, 32'd3, 32'd4, 32'h0000_000C, 1'b0, "mul_after_flush");

        // i_Start held high through DONE must yield a single completion.
        i_Start   = 1'b1;
        i_Funct3  = 3'b000;
        i_Source1 = 32'd5;
        i_Source2 = 32'd6;
        repeat (33) tick;
        check_eq("hold_done", {31'd0, o_Done}, 32'd1);
        check_eq("hold_result", o_Result, 32'd30);
        tick;
        i_Start = 1'b0;
        check_eq("hold_no_reaccept", {31'd0, o_Busy}, 32'd0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_Done) done_n++;
            tick;
        end
        check_eq("hold_extra_done", done_n, 32'd0);

        // Reset during RUN cycle 5.
        i_Start   = 1'b1;
        i_Funct3  = 3'b000;
        i_Source1 = 32'd9;
        i_Source2 = 32'd9;
        tick;
        i_Start = 1'b0;
        repeat (4) tick;
        i_Reset_n = 1'b0;
        #1;
        check_eq("rrun_stall_low", {31'd0, o_Stall}, 32'd0);
        tick;
        check_eq("rrun_busy", {31'd0, o_Busy}, 32'd0);
        check_eq("rrun_done", {31'd0, o_Done}, 32'd0);
        check_eq("rrun_result", o_Result, 32'd0);
        check_eq("rrun_stall", {31'd0, o_Stall}, 32'd0);
        check_eq("rrun_state", {30'd0, o_State}, 32'd0);
        i_Reset_n = 1'b1;
        tick;
        check_eq("rrun_busy_rel", {31'd0, o_Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
